// File: rtl/sph_pkg.sv
// sph_pkg: shared task-type constants, scheduler state enum and field indices for the SPH pair scheduler
package sph_pkg;
  localparam logic [1:0] TASK_DENSITY = 2'b00;
  localparam logic [1:0] TASK_FORCE = 2'b01;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_I, S_ISSUE_J, S_DRAIN, S_WAIT_RESULT, S_WRITE, S_DONE
  } sched_state_e;
  localparam int F_XI = 4;
  localparam int F_XJ = 3;
  localparam int F_PI = 2;
  localparam int F_PJ = 1;
  localparam int F_RHO = 0;
  localparam int RD_X = 2;
  localparam int RD_P = 1;
  localparam int RD_RHO = 0;
endpackage

// File: rtl/pair_scheduler_rd_valid_pipe.sv
// rd_valid_pipe: DEPTH-stage shift register tagging each outstanding particle read with {valid, last}
//   in_valid/in_last   tag of the address issued this cycle
//   out_valid/out_last tag of the read data arriving this cycle
module rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);
  logic [DEPTH-1:0][1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = {in_valid, in_last};
    for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) pipe_q <= '0;
    else pipe_q <= pipe_d;
  assign out_valid = pipe_q[DEPTH-1][1];
  assign out_last = pipe_q[DEPTH-1][0];
endmodule

// File: rtl/pair_scheduler.sv
// pair_scheduler: walks all (i, j) particle pairs, streams tasks to the compute block, writes per-i results
//   start/task_sel -> busy/done, sticky err_timeout/err_unexpected
//   rd_addr/rd_data     particle memory (fixed READ_LATENCY)
//   task_*              one task beat per cycle, no backpressure
//   result_valid/result reduced result per i; wr_* result memory write
module pair_scheduler
  import sph_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_PARTICLES = 4,
  parameter int ADDR_WIDTH = $clog2(N_PARTICLES),
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              task_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_unexpected,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [3*DATA_WIDTH-1:0] rd_data,
  output logic                    task_valid,
  output logic [1:0]              task_type,
  output logic [5*DATA_WIDTH-1:0] task_data,
  output logic                    task_last,
  input  logic                    result_valid,
  input  logic [DATA_WIDTH-1:0]   result,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data
);
  localparam int CW = $clog2(READ_LATENCY + TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_PARTICLES - 1);
  sched_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] type_q, type_d;
  logic [DATA_WIDTH-1:0] xi_q, xi_d, pi_q, pi_d, res_q, res_d;
  logic err_to_q, err_to_d, err_ux_q, err_ux_d;
  logic pipe_valid, pipe_last;
  rd_valid_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
    .clk_in    (clk_in),
    .rst       (rst),
    .in_valid  (state_q == S_ISSUE_J),
    .in_last   (j_q == LAST),
    .out_valid (pipe_valid),
    .out_last  (pipe_last)
  );
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    cnt_d = cnt_q;
    type_d = type_q;
    xi_d = xi_q;
    pi_d = pi_q;
    res_d = res_q;
    err_to_d = err_to_q;
    err_ux_d = err_ux_q | (result_valid && state_q != S_WAIT_RESULT);
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_FETCH_I;
          type_d = task_sel;
          i_d = '0;
          cnt_d = '0;
          err_to_d = 1'b0;
          // a stray result on the accepting cycle is still reported
          err_ux_d = result_valid;
        end
      S_FETCH_I: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(READ_LATENCY)) begin
          xi_d = rd_data[RD_X*DATA_WIDTH +: DATA_WIDTH];
          pi_d = rd_data[RD_P*DATA_WIDTH +: DATA_WIDTH];
          j_d = '0;
          state_d = S_ISSUE_J;
        end
      end
      S_ISSUE_J:
        if (j_q == LAST) state_d = S_DRAIN;
        else j_d = j_q + ADDR_WIDTH'(1);
      S_DRAIN:
        if (pipe_valid && pipe_last) begin
          state_d = S_WAIT_RESULT;
          cnt_d = '0;
        end
      S_WAIT_RESULT:
        // result takes priority over the timeout compare in the same cycle
        if (result_valid) begin
          res_d = result;
          state_d = S_WRITE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + CW'(1);
      S_WRITE:
        if (i_q == LAST) state_d = S_DONE;
        else begin
          i_d = i_q + ADDR_WIDTH'(1);
          cnt_d = '0;
          state_d = S_FETCH_I;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      i_q <= '0;
      j_q <= '0;
      cnt_q <= '0;
      type_q <= '0;
      xi_q <= '0;
      pi_q <= '0;
      res_q <= '0;
      err_to_q <= 1'b0;
      err_ux_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      cnt_q <= cnt_d;
      type_q <= type_d;
      xi_q <= xi_d;
      pi_q <= pi_d;
      res_q <= res_d;
      err_to_q <= err_to_d;
      err_ux_q <= err_ux_d;
    end
  always_comb begin
    task_data = '0;
    if (pipe_valid) begin
      task_data[F_XI*DATA_WIDTH +: DATA_WIDTH] = xi_q;
      task_data[F_XJ*DATA_WIDTH +: DATA_WIDTH] = rd_data[RD_X*DATA_WIDTH +: DATA_WIDTH];
      task_data[F_PI*DATA_WIDTH +: DATA_WIDTH] = pi_q;
      task_data[F_PJ*DATA_WIDTH +: DATA_WIDTH] = rd_data[RD_P*DATA_WIDTH +: DATA_WIDTH];
      task_data[F_RHO*DATA_WIDTH +: DATA_WIDTH] = rd_data[RD_RHO*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign err_timeout = err_to_q;
  assign err_unexpected = err_ux_q;
  assign rd_addr = (state_q == S_FETCH_I && cnt_q == '0) ? i_q : state_q == S_ISSUE_J ? j_q : '0;
  assign task_valid = pipe_valid;
  assign task_last = pipe_valid & pipe_last;
  assign task_type = type_q;
  assign wr_en = state_q == S_WRITE;
  assign wr_addr = wr_en ? i_q : '0;
  assign wr_data = wr_en ? res_q : '0;
endmodule

// File: tb/tb_pair_scheduler.sv
// tb_pair_scheduler: table-driven, hand-written and randomized checks of pair_scheduler against a pair-enumeration model
module tb_pair_scheduler;
  import sph_pkg::*;
  localparam int DW = 16, N = 4, AW = 2, RL = 2, TO = 64;
  logic clk_in = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] task_sel = 2'b00;
  logic busy, done, err_timeout, err_unexpected, task_valid, task_last, wr_en, result_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3*DW-1:0] rd_data, rd_s1;
  logic [1:0] task_type;
  logic [5*DW-1:0] task_data;
  logic [DW-1:0] result, wr_data;
  logic [DW-1:0] mx [N], mp [N], mr [N];
  logic stub_rv = 1'b0;
  logic [DW-1:0] stub_res = '0;
  int stub_cd = 0, stub_n = 0, stub_lat = 4;
  bit stub_on = 1'b1;
  logic inj_rv = 1'b0;
  logic [DW-1:0] inj_res = 16'hDEAD;
  int cyc = 0, n_done = 0, to_cyc = -1;
  logic to_prev = 1'b0;
  logic [82:0] beats [$];
  int bcyc [$];
  logic [17:0] wrs [$];
  int nvec = 0, nmis = 0;
  logic [108:0] all_out;

  pair_scheduler #(.DATA_WIDTH(DW), .N_PARTICLES(N), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .task_sel(task_sel), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_unexpected(err_unexpected), .rd_addr(rd_addr), .rd_data(rd_data),
    .task_valid(task_valid), .task_type(task_type), .task_data(task_data), .task_last(task_last),
    .result_valid(result_valid), .result(result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk_in = ~clk_in;
  assign result_valid = stub_rv | inj_rv;
  assign result = inj_rv ? inj_res : stub_res;
  assign all_out = {busy, done, err_timeout, err_unexpected, rd_addr, task_valid, task_type,
                    task_data, task_last, wr_en, wr_addr, wr_data};

  // particle memory with a two-cycle read pipeline
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    rd_s1 <= {mx[rd_addr], mp[rd_addr], mr[rd_addr]};
    rd_data <= rd_s1;
  end

  // compute stub: answers stub_lat cycles after each task_last with 0x5000 + burst index
  always @(posedge clk_in) begin
    stub_rv <= 1'b0;
    if (start && !busy) stub_n <= 0;
    if (task_last && stub_on) begin
      stub_cd <= stub_lat;
      stub_res <= 16'h5000 + 16'(stub_n);
      stub_n <= stub_n + 1;
    end else if (stub_cd > 0) begin
      stub_cd <= stub_cd - 1;
      stub_rv <= (stub_cd == 1);
    end
  end

  always @(negedge clk_in) begin
    if (task_valid) begin
      beats.push_back({task_last, task_type, task_data});
      bcyc.push_back(cyc);
    end
    if (wr_en) wrs.push_back({wr_addr, wr_data});
    if (done) n_done++;
    if (err_timeout && !to_prev) to_cyc = cyc;
    to_prev = err_timeout;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [82:0] exp_beat(int i, int j, logic [1:0] t);
    return {j == N - 1, t, mx[i], mx[j], mp[i], mp[j], mr[j]};
  endfunction

  task automatic begin_pass(input logic [1:0] sel, output int b0, output int w0, output int d0, output int s0);
    @(negedge clk_in);
    b0 = beats.size(); w0 = wrs.size(); d0 = n_done; s0 = cyc;
    start = 1'b1; task_sel = sel;
    @(negedge clk_in);
    start = 1'b0; task_sel = ~sel;
  endtask

  task automatic run_pass(input logic [1:0] sel, input bit spam, input bit inject,
                          output int b0, output int w0, output int d0, output int s0);
    bit injected = 1'b0;
    begin_pass(sel, b0, w0, d0, s0);
    for (int k = 0; k < 3000 && n_done == d0; k++) begin
      start = spam && busy && !done && (k % 3 == 0);
      inj_rv = inject && !injected && task_valid;
      if (inj_rv) injected = 1'b1;
      @(negedge clk_in);
    end
    start = 1'b0; inj_rv = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic check_pass(input string tag, input logic [1:0] sel, input int b0, input int w0,
                            input int d0, input int s0, input int n_i, input int n_w);
    check({tag, "_beats"}, beats.size() - b0, n_i * N);
    check({tag, "_writes"}, wrs.size() - w0, n_w);
    check({tag, "_done"}, n_done - d0, 1);
    check({tag, "_busy"}, busy, 0);
    if (beats.size() > b0) check({tag, "_first_lat"}, bcyc[b0] - s0, 2 + 2 * RL);
    for (int k = 0; k < n_i * N && b0 + k < beats.size(); k++)
      check($sformatf("%s_beat%0d", tag, k), beats[b0 + k], exp_beat(k / N, k % N, sel));
    for (int k = 0; k < n_w && w0 + k < wrs.size(); k++)
      check($sformatf("%s_wr%0d", tag, k), wrs[w0 + k], {2'(k), 16'h5000 + 16'(k)});
  endtask

  typedef struct {
    logic [1:0] sel;
    bit respond, inject, spam;
    int n_i, n_w;
    logic to, ux;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int b0, w0, d0, s0;
    logic [1:0] sel;
    tbl[0] = '{TASK_DENSITY, 1'b1, 1'b0, 1'b0, 4, 4, 1'b0, 1'b0};
    tbl[1] = '{TASK_FORCE,   1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 1'b0};
    tbl[2] = '{TASK_DENSITY, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
    tbl[3] = '{TASK_FORCE,   1'b1, 1'b1, 1'b0, 4, 4, 1'b0, 1'b1};
    tbl[4] = '{2'b10,        1'b1, 1'b0, 1'b0, 4, 4, 1'b0, 1'b0};
    mx[0] = 16'h0000; mx[1] = 16'h3C00; mx[2] = 16'h4000; mx[3] = 16'h4200;
    foreach (mp[k]) begin mp[k] = mx[k]; mr[k] = 16'h3C00; end
    repeat (2) @(negedge clk_in);
    check("reset_outputs", all_out, 0);
    rst = 1'b0;

    foreach (tbl[r]) begin
      stub_on = tbl[r].respond;
      stub_lat = 4;
      run_pass(tbl[r].sel, tbl[r].spam, tbl[r].inject, b0, w0, d0, s0);
      check_pass($sformatf("row%0d", r), tbl[r].sel, b0, w0, d0, s0, tbl[r].n_i, tbl[r].n_w);
      check($sformatf("row%0d_err_timeout", r), err_timeout, tbl[r].to);
      check($sformatf("row%0d_err_unexpected", r), err_unexpected, tbl[r].ux);
      if (tbl[r].to && beats.size() > 0) check("timeout_cycles", to_cyc - bcyc[beats.size() - 1], TO + 1);
      if (r == 0) begin
        if (beats.size() > b0 + 6) check("beat_i1_j2", beats[b0 + 6][79:0], 80'h3C00_4000_3C00_4000_3C00);
        for (int k = 1; k < N * N && b0 + k < bcyc.size(); k++)
          if (k % N != 0) check($sformatf("burst_gap%0d", k), bcyc[b0 + k] - bcyc[b0 + k - 1], 1);
      end
    end

    stub_on = 1'b1;
    begin_pass(TASK_FORCE, b0, w0, d0, s0);
    for (int k = 0; k < 500 && beats.size() < b0 + 2 * N + 1; k++) @(negedge clk_in);
    check("mid_reach_i2", beats.size() >= b0 + 2 * N + 1, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", all_out, 0);
    repeat (4) @(negedge clk_in);
    check("mid_rst_done", n_done - d0, 0);
    check("mid_rst_writes", wrs.size() - w0, 2);
    rst = 1'b0;
    run_pass(TASK_DENSITY, 1'b0, 1'b0, b0, w0, d0, s0);
    check_pass("post_rst", TASK_DENSITY, b0, w0, d0, s0, N, N);

    for (int p = 0; p < 6; p++) begin
      foreach (mx[k]) begin
        mx[k] = 16'($urandom); mp[k] = 16'($urandom); mr[k] = 16'($urandom);
      end
      stub_lat = $urandom_range(1, 20);
      sel = 2'($urandom_range(0, 3));
      run_pass(sel, 1'b0, 1'b0, b0, w0, d0, s0);
      check_pass($sformatf("rand%0d", p), sel, b0, w0, d0, s0, N, N);
      check($sformatf("rand%0d_errs", p), {err_timeout, err_unexpected}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
